// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, PSR flag indices and decode classes.
// Imported by the ALU, the decoder and the writeback stage.
package cpu_pkg;

    localparam int unsigned FLAG_W = 5;

    // PSR / ALU flag bit positions
    localparam int unsigned Z = 4;
    localparam int unsigned C = 3;
    localparam int unsigned F = 2;
    localparam int unsigned N = 1;
    localparam int unsigned L = 0;

    // opcode[15:12]
    localparam logic [3:0] R_TO_R = 4'b0000;
    localparam logic [3:0] ANDI   = 4'b0001;
    localparam logic [3:0] ORI    = 4'b0010;
    localparam logic [3:0] XORI   = 4'b0011;
    localparam logic [3:0] ADDI   = 4'b0101;
    localparam logic [3:0] ADDUI  = 4'b0110;
    localparam logic [3:0] ADDCI  = 4'b0111;
    localparam logic [3:0] SHIFT  = 4'b1000;
    localparam logic [3:0] SUBI   = 4'b1001;
    localparam logic [3:0] SUBCI  = 4'b1010;
    localparam logic [3:0] CMPI   = 4'b1011;
    localparam logic [3:0] MOVI   = 4'b1101;
    localparam logic [3:0] MULI   = 4'b1110;
    localparam logic [3:0] LUI    = 4'b1111;

    // opcode[7:4] within R_TO_R
    localparam logic [3:0] AND    = 4'b0001;
    localparam logic [3:0] OR     = 4'b0010;
    localparam logic [3:0] XOR    = 4'b0011;
    localparam logic [3:0] ADD    = 4'b0101;
    localparam logic [3:0] ADDU   = 4'b0110;
    localparam logic [3:0] ADDC   = 4'b0111;
    localparam logic [3:0] SUB    = 4'b1001;
    localparam logic [3:0] SUBC   = 4'b1010;
    localparam logic [3:0] CMP    = 4'b1011;
    localparam logic [3:0] MOV    = 4'b1101;
    localparam logic [3:0] MUL    = 4'b1110;

    // opcode[7:4] within SHIFT
    localparam logic [3:0] LLSHI  = 4'b0000;
    localparam logic [3:0] LRSHI  = 4'b0001;
    localparam logic [3:0] ALSHI  = 4'b0010;
    localparam logic [3:0] ARSHI  = 4'b0011;
    localparam logic [3:0] LSH    = 4'b0100;
    localparam logic [3:0] ASH    = 4'b0110;

    typedef enum logic [1:0] {
        ClsArith,
        ClsCmp,
        ClsPlain,
        ClsIllegal
    } op_class_e;

    localparam logic [FLAG_W-1:0] MASK_ARITH = FLAG_W'((1 << C) | (1 << F));
    localparam logic [FLAG_W-1:0] MASK_CMP   = FLAG_W'((1 << L) | (1 << N) | (1 << Z));

    function automatic logic [FLAG_W-1:0] class_mask(op_class_e cls);
        logic [FLAG_W-1:0] mask;
        mask = '0;
        if (cls == ClsArith) begin
            mask = MASK_ARITH;
        end else if (cls == ClsCmp) begin
            mask = MASK_CMP;
        end
        return mask;
    endfunction

    function automatic logic class_writes(op_class_e cls);
        return (cls == ClsArith) || (cls == ClsPlain);
    endfunction

endpackage

// File: rtl/wb_decode.sv
// Combinational opcode decode for writeback: PSR update mask, register write
// enable and undefined-opcode detection. Shared with the decoder stage.
module wb_decode
    import cpu_pkg::*;
(
    input  logic [15:0]       opcode,
    output logic [FLAG_W-1:0] flag_mask,
    output logic              wr_en,
    output logic              illegal
);

    op_class_e w_class;
    logic [3:0] w_hi;
    logic [3:0] w_lo;

    assign w_hi = opcode[15:12];
    assign w_lo = opcode[7:4];

    always_comb begin
        w_class = ClsIllegal;
        case (w_hi)
            R_TO_R: begin
                case (w_lo)
                    ADD, ADDC, SUB, SUBC:          w_class = ClsArith;
                    CMP:                           w_class = ClsCmp;
                    ADDU, MUL, AND, OR, XOR, MOV:  w_class = ClsPlain;
                    default:                       w_class = ClsIllegal;
                endcase
            end
            SHIFT: begin
                case (w_lo)
                    LLSHI, LRSHI, ALSHI, ARSHI, LSH, ASH: w_class = ClsPlain;
                    default:                              w_class = ClsIllegal;
                endcase
            end
            ADDI, ADDCI, SUBI, SUBCI:                   w_class = ClsArith;
            CMPI:                                       w_class = ClsCmp;
            ANDI, ORI, XORI, ADDUI, MOVI, MULI, LUI:    w_class = ClsPlain;
            default:                                    w_class = ClsIllegal;
        endcase
    end

    assign flag_mask = class_mask(w_class);
    assign wr_en     = class_writes(w_class);
    assign illegal   = (w_class == ClsIllegal);

endmodule

// File: rtl/psr_writeback.sv
// Execute-to-writeback stage: PSR register, one-entry register-file write
// buffer with valid/ready handshake, illegal pulse and retired counter.
module psr_writeback
    import cpu_pkg::*;
#(
    parameter int unsigned RET_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       opcode,
    input  logic [15:0]       alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              psr_load,
    input  logic [FLAG_W-1:0] psr_wdata,
    output logic [FLAG_W-1:0] psr,
    output logic              carry_out,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [3:0]        wb_addr,
    output logic [15:0]       wb_data,
    output logic              illegal,
    output logic [RET_W-1:0]  retired
);

    logic              w_accept;
    logic              w_wb_done;
    logic              w_wr_en;
    logic              w_dec_illegal;
    logic [FLAG_W-1:0] w_dec_mask;
    logic [FLAG_W-1:0] w_upd_mask;
    logic [FLAG_W-1:0] w_psr_base;
    logic [FLAG_W-1:0] w_psr_d;

    logic              w_wb_valid_d;
    logic [3:0]        w_wb_addr_d;
    logic [15:0]       w_wb_data_d;

    logic [FLAG_W-1:0] r_psr;
    logic              r_wb_valid;
    logic [3:0]        r_wb_addr;
    logic [15:0]       r_wb_data;
    logic              r_illegal;
    logic [RET_W-1:0]  r_retired;

    wb_decode u_wb_decode (
        .opcode    (opcode),
        .flag_mask (w_dec_mask),
        .wr_en     (w_wr_en),
        .illegal   (w_dec_illegal)
    );

    assign in_ready  = !r_wb_valid || wb_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_wb_done = r_wb_valid && wb_ready;

    // Masking by AND keeps unmasked (possibly X) ALU flags out of the PSR;
    // the instruction's masked bits override a same-cycle software write.
    always_comb begin
        w_upd_mask = w_accept ? w_dec_mask : '0;
        w_psr_base = psr_load ? psr_wdata : r_psr;
        w_psr_d    = (w_psr_base & ~w_upd_mask) | (alu_flags & w_upd_mask);
    end

    always_comb begin
        w_wb_valid_d = r_wb_valid;
        w_wb_addr_d  = r_wb_addr;
        w_wb_data_d  = r_wb_data;
        if (w_accept && w_wr_en) begin
            w_wb_valid_d = 1'b1;
            w_wb_addr_d  = opcode[11:8];
            w_wb_data_d  = alu_out;
        end else if (w_wb_done) begin
            w_wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_psr      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_illegal  <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_psr      <= w_psr_d;
            r_wb_valid <= w_wb_valid_d;
            r_wb_addr  <= w_wb_addr_d;
            r_wb_data  <= w_wb_data_d;
            r_illegal  <= w_accept && w_dec_illegal;
            if (w_accept) begin
                r_retired <= r_retired + RET_W'(1);
            end
        end
    end

    assign psr       = r_psr;
    assign carry_out = r_psr[C];
    assign wb_valid  = r_wb_valid;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign illegal   = r_illegal;
    assign retired   = r_retired;

endmodule

// File: tb/tb_psr_writeback.sv
// Directed bench for psr_writeback: expected register writes go into a queue
// checked by an independent monitor; PSR/counter/pulse values checked inline.
module tb_psr_writeback;

    localparam int unsigned RET_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      opcode;
    logic [15:0]      alu_out;
    logic [4:0]       alu_flags;
    logic             psr_load;
    logic [4:0]       psr_wdata;
    logic [4:0]       psr;
    logic             carry_out;
    logic             wb_valid;
    logic             wb_ready;
    logic [3:0]       wb_addr;
    logic [15:0]      wb_data;
    logic             illegal;
    logic [RET_W-1:0] retired;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    int      n_checks = 0;
    int      n_fail   = 0;

    psr_writeback #(.RET_W(RET_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .psr_load  (psr_load),
        .psr_wdata (psr_wdata),
        .psr       (psr),
        .carry_out (carry_out),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] op, input logic [15:0] res, input logic [4:0] fl);
        in_valid  = 1'b1;
        opcode    = op;
        alu_out   = res;
        alu_flags = fl;
    endtask

    // Idle inputs look like a flag-setting ADD so a leak past in_valid would show.
    task automatic idle();
        in_valid  = 1'b0;
        opcode    = 16'h0150;
        alu_out   = 16'hFFFF;
        alu_flags = 5'b11111;
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        wb_exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: a completed write is observed mid-cycle before the edge that retires it.
    always @(negedge clk) begin
        if (reset_n && wb_valid && wb_ready) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("mon_wb_addr", 32'(wb_addr), 32'(mon_e.addr));
                check("mon_wb_data", 32'(wb_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        wb_ready  = 1'b1;
        psr_load  = 1'b0;
        psr_wdata = '0;
        idle();
        step();
        step();
        check("rst_psr",      32'(psr),       32'h00);
        check("rst_carry",    32'(carry_out), 32'h0);
        check("rst_wb_valid", 32'(wb_valid),  32'h0);
        check("rst_wb_addr",  32'(wb_addr),   32'h0);
        check("rst_wb_data",  32'(wb_data),   32'h0);
        check("rst_illegal",  32'(illegal),   32'h0);
        check("rst_retired",  32'(retired),   32'h0);
        check("rst_in_ready", 32'(in_ready),  32'h1);
        reset_n = 1'b1;
        step();

        // ADD sets carry, ADDC then clears it
        drive(16'h0150, 16'h0000, 5'b01000);
        push(4'd1, 16'h0000);
        step();
        check("add_psr",      32'(psr),       32'h08);
        check("add_carry",    32'(carry_out), 32'h1);
        check("add_wb_valid", 32'(wb_valid),  32'h1);
        check("add_wb_addr",  32'(wb_addr),   32'h1);
        check("add_wb_data",  32'(wb_data),   32'h0);
        check("add_retired",  32'(retired),   32'h1);
        drive(16'h0273, 16'h1234, 5'b00000);
        push(4'd2, 16'h1234);
        step();
        idle();
        check("addc_psr",     32'(psr),       32'h00);
        check("addc_carry",   32'(carry_out), 32'h0);
        check("addc_wb_addr", 32'(wb_addr),   32'h2);
        check("addc_wb_data", 32'(wb_data),   32'h1234);
        check("addc_retired", 32'(retired),   32'h2);

        // software PSR write, then CMPI
        psr_load  = 1'b1;
        psr_wdata = 5'b01100;
        step();
        psr_load = 1'b0;
        check("load_psr",      32'(psr),      32'h0C);
        check("load_wb_valid", 32'(wb_valid), 32'h0);
        drive(16'hB2FF, 16'hDEAD, 5'b10011);
        step();
        idle();
        check("cmpi_psr",      32'(psr),       32'h1F);
        check("cmpi_wb_valid", 32'(wb_valid),  32'h0);
        check("cmpi_retired",  32'(retired),   32'h3);
        check("cmpi_carry",    32'(carry_out), 32'h1);

        // backpressure: stalled second ADD must not touch the PSR
        wb_ready = 1'b0;
        drive(16'h0350, 16'hAAAA, 5'b01000);
        push(4'd3, 16'hAAAA);
        step();
        check("bp1_psr",      32'(psr),      32'h1B);
        check("bp1_wb_valid", 32'(wb_valid), 32'h1);
        check("bp1_in_ready", 32'(in_ready), 32'h0);
        check("bp1_retired",  32'(retired),  32'h4);
        drive(16'h0450, 16'hBBBB, 5'b00100);
        step();
        check("stall_psr",      32'(psr),      32'h1B);
        check("stall_retired",  32'(retired),  32'h4);
        check("stall_wb_addr",  32'(wb_addr),  32'h3);
        check("stall_wb_data",  32'(wb_data),  32'hAAAA);
        check("stall_in_ready", 32'(in_ready), 32'h0);
        wb_ready = 1'b1;
        push(4'd4, 16'hBBBB);
        step();
        idle();
        check("b2b_wb_valid", 32'(wb_valid), 32'h1);
        check("b2b_wb_addr",  32'(wb_addr),  32'h4);
        check("b2b_wb_data",  32'(wb_data),  32'hBBBB);
        check("b2b_psr",      32'(psr),      32'h17);
        check("b2b_retired",  32'(retired),  32'h5);

        // undefined high nibble
        drive(16'h4000, 16'h0000, 5'b11111);
        step();
        idle();
        check("ill_pulse",    32'(illegal),  32'h1);
        check("ill_psr",      32'(psr),      32'h17);
        check("ill_retired",  32'(retired),  32'h6);
        check("ill_wb_valid", 32'(wb_valid), 32'h0);
        step();
        check("ill_end",      32'(illegal),  32'h0);
        check("ill_retired2", 32'(retired),  32'h6);

        // software write racing an accepted SUB
        psr_load  = 1'b1;
        psr_wdata = 5'b11111;
        drive(16'h0590, 16'h0055, 5'b00000);
        push(4'd5, 16'h0055);
        step();
        idle();
        psr_load = 1'b0;
        check("sub_ld_psr",     32'(psr),       32'h13);
        check("sub_ld_carry",   32'(carry_out), 32'h0);
        check("sub_ld_retired", 32'(retired),   32'h7);
        check("sub_ld_wb_data", 32'(wb_data),   32'h0055);

        // SHIFT: LSH writes without flags, low nibble 0101 is undefined
        drive(16'h8740, 16'h0F0F, 5'b11111);
        push(4'd7, 16'h0F0F);
        step();
        idle();
        check("lsh_psr",     32'(psr),     32'h13);
        check("lsh_illegal", 32'(illegal), 32'h0);
        check("lsh_wb_addr", 32'(wb_addr), 32'h7);
        check("lsh_retired", 32'(retired), 32'h8);
        drive(16'h8150, 16'h1111, 5'b11111);
        step();
        idle();
        check("shill_pulse",   32'(illegal), 32'h1);
        check("shill_retired", 32'(retired), 32'h9);
        check("shill_psr",     32'(psr),     32'h13);
        check("drained", 32'(exp_q.size()), 32'd0);

        // counter wrap with RET_W=4: 17 accepts from reset land on 1
        reset_n = 1'b0;
        step();
        check("rst2_retired", 32'(retired), 32'h0);
        reset_n = 1'b1;
        step();
        drive(16'h00B0, 16'h0000, 5'b10011);
        for (int i = 0; i < 17; i++) begin
            step();
            if (i == 14) begin
                check("wrap_15", 32'(retired), 32'hF);
            end
        end
        idle();
        check("wrap_retired",  32'(retired),  32'h1);
        check("wrap_psr",      32'(psr),      32'h13);
        check("wrap_wb_valid", 32'(wb_valid), 32'h0);

        // asynchronous reset drops a pending write
        wb_ready = 1'b0;
        drive(16'h0D70, 16'h7777, 5'b11111);
        step();
        idle();
        check("pend_wb_valid", 32'(wb_valid), 32'h1);
        check("pend_wb_data",  32'(wb_data),  32'h7777);
        check("pend_retired",  32'(retired),  32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_psr",      32'(psr),       32'h0);
        check("arst_carry",    32'(carry_out), 32'h0);
        check("arst_wb_valid", 32'(wb_valid),  32'h0);
        check("arst_wb_addr",  32'(wb_addr),   32'h0);
        check("arst_wb_data",  32'(wb_data),   32'h0);
        check("arst_illegal",  32'(illegal),   32'h0);
        check("arst_retired",  32'(retired),   32'h0);
        wb_ready = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        step();
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("final_wb_valid", 32'(wb_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psr_writeback.md
# psr_writeback

Execute-to-writeback stage directly downstream of the combinational ALU. Captures the ALU result and raw flags, decides per opcode which PSR flag bits update and whether the register file is written, and holds the program status register (PSR) whose carry bit feeds the ALU `carry_in`. A one-entry output register with a valid/ready handshake isolates the register-file write port. A wrapping counter tracks retired instructions.

## Interface
- `RET_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: ALU result, flags and opcode are valid this cycle.
- `in_ready` out 1: stage accepts this cycle. Transfer happens when `in_valid && in_ready`.
- `opcode` in 16: the instruction word driven to the ALU.
- `alu_out` in 16: ALU result.
- `alu_flags` in 5: raw ALU flags. Bit indices: Z=4, C=3, F=2, N=1, L=0.
- `psr_load` in 1: software write of the PSR.
- `psr_wdata` in 5: value for `psr_load`.
- `psr` out 5: current PSR.
- `carry_out` out 1: equals `psr[3]`. Wired to ALU `carry_in`.
- `wb_valid` out 1: a write is pending.
- `wb_ready` in 1: register file accepts the write.
- `wb_addr` out 4: destination register, `opcode[11:8]` of the captured instruction.
- `wb_data` out 16: captured `alu_out`.
- `illegal` out 1: one-cycle pulse when an accepted opcode is undefined.
- `retired` out RET_W: count of accepted instructions.

## Operation
- **Opcode classes.** Classes come from `opcode[15:12]`. For the R_TO_R (0000) and SHIFT (1000) classes, `opcode[7:4]` is also decoded.
- **Arithmetic with carry/overflow.** ADD/ADDI, ADDC/ADDCI, SUB/SUBI, SUBC/SUBCI: update mask {C,F}; write back.
- **Compare.** CMP/CMPI: update mask {L,N,Z}; no writeback.
- **Other defined ops.** ADDU/ADDUI, MUL/MULI, AND/OR/XOR (+I), MOV/MOVI, LUI, and SHIFT sub-ops {0000,0001,0010,0011,0100,0110}: update mask empty; write back.
- **Undefined opcodes.** Any other R_TO_R low nibble, SHIFT low nibble, or high nibble (0100, 1100): mask empty, no writeback. Pulse `illegal` the cycle after acceptance. The instruction still counts as retired.
- **PSR update on accept.** `psr[i] <= alu_flags[i]` for each masked bit. Unmasked bits hold. ALU flag bits outside the mask are ignored, even if X.
- **Software PSR write.** On `psr_load`, bits not masked by a same-cycle accepted instruction take `psr_wdata`. Masked bits take `alu_flags`, so the instruction wins.
- **Output register.**
  - `in_ready = !wb_valid || wb_ready`.
  - An accepted write-back instruction loads `wb_addr`/`wb_data` and sets `wb_valid`.
  - A write completes when `wb_valid && wb_ready`.
  - If a non-writing instruction is accepted while no new write is loaded, `wb_valid` clears on completion.
  - Simultaneous completion and new load gives a back-to-back write with no bubble.
- **Stall.** While `in_ready` is 0, `opcode`/`alu_out`/`alu_flags` are ignored and the PSR does not update from the instruction. `psr_load` is still honoured.
- **Counter.** `retired` increments on every accept and wraps from all-ones to 0.

## Timing
- **Reset** (asynchronous assert, synchronous-edge deassert): `psr`=0, `carry_out`=0, `wb_valid`=0, `wb_addr`=0, `wb_data`=0, `illegal`=0, `retired`=0.
- **Latency.** Accept at edge N; `psr`, `carry_out`, `wb_*`, `illegal` and `retired` reflect it after edge N. An ADDC issued in cycle N+1 therefore sees the carry from the instruction accepted at N. No forwarding is required beyond this.
- **`in_ready`** is combinational from `wb_valid` and `wb_ready`. There is no combinational path from `in_valid` to `in_ready`.
- **Handshake stability.** `wb_valid`, `wb_addr` and `wb_data` hold stable until accepted.
- **Reset mid-operation.** A pending write is dropped and the PSR is cleared.

## Structure
- **Shared package `cpu_pkg`:**
  - opcode-high and opcode-low localparams (R_TO_R, ADDI…LUI; ADD…MOV; LSH, LLSHI, LRSHI, ASH, ALSHI, ARSHI);
  - flag index constants Z, C, F, N, L;
  - flag-mask width of 5.
  The ALU is migrated to import the same package.
- **Sub-module `wb_decode`:** combinational; `opcode` → `flag_mask[4:0]`, `wr_en`, `illegal`. Keep it separate so the decoder stage can reuse it.
- **Top level:** PSR register, output register and counter.

## Test plan
- **Carry, then ADDC.** Reset, then accept ADD (`opcode`=16'h0150) with `alu_flags`=5'b01000 and `alu_out`=16'h0000 → next cycle `psr`=5'b01000, `carry_out`=1, `wb_addr`=1, `wb_data`=0. Then ADDC with `alu_flags`=0 → C clears.
- **Compare.** CMPI (16'hB2FF) with `alu_flags`=5'b10011 and `psr`=5'b01100 beforehand → `psr`=5'b11111, `wb_valid` stays 0, `retired` increments.
- **Backpressure.** Hold `wb_ready`=0 with a write pending → `in_ready`=0 and a second ADD with `alu_flags`=5'b01000 leaves `psr` unchanged. Raise `wb_ready` → the first write completes, the second is accepted in the same cycle, and the next cycle presents its data.
- **Illegal opcode.** 16'h4000 → `illegal` high for exactly one cycle, no write, `psr` unchanged, `retired` +1.
- **Simultaneous PSR write.** `psr_load` with `psr_wdata`=5'b11111 in the same cycle as an accepted SUB with `alu_flags`=0 → `psr`=5'b10011.
- **Wrap and reset.** With RET_W=4, 17 accepts → `retired`=1. Assert `reset_n`=0 asynchronously while `wb_valid`=1 → all outputs 0 immediately.
